led3_pattern_sequencer: RTL and testbench

- Mode controller and sequencer for the board's four RGB LEDs (4×R, 4×G, 4×B, active-high).
- Decodes button presses into a display mode.
- Steps a time-based pattern per mode and drives the LED lines through a shared 8-bit PWM comparator.
- Sits between the board button inputs and the LED pins; replaces ad-hoc per-LED control with one scheduled sequence.

---
 rtl/led3_pattern_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_led3_pattern_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led3_pattern_sequencer.sv
// Button-selected LED pattern sequencer for four RGB LEDs.
// Modes are decoded from button presses; duties go through a shared 8-bit PWM.

module led3_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= 1'b0;
      led_g <= 1'b0;
      led_b <= 1'b0;
    end else begin
      led_r <= duty_r > pwm_cnt;
      led_g <= duty_g > pwm_cnt;
      led_b <= duty_b > pwm_cnt;
    end
  end
endmodule

module led3_pattern_sequencer #(
  parameter int TICK_DIV    = 10000,
  parameter int BLINK_TICKS = 50,
  parameter int ROT_TICKS   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  output logic [3:0] led_signal_R,
  output logic [3:0] led_signal_G,
  output logic [3:0] led_signal_B,
  output logic [2:0] mode
);
  localparam int NUM_LANES = 4;
  localparam int MAXT      = (BLINK_TICKS > ROT_TICKS) ? BLINK_TICKS : ROT_TICKS;
  localparam int SW        = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW-1:0] BLINK_LAST = SW'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] ROT_LAST   = SW'(ROT_TICKS - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_STATIC  = 3'd1,
    M_BLINK   = 3'd2,
    M_ROTATE  = 3'd3,
    M_BREATHE = 3'd4
  } mode_e;

  mode_e           state_q, state_d;
  logic [7:0]      btn_q, edge_v;
  logic            btn_hit;
  logic [2:0]      sel_idx;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [7:0]      pwm_cnt;
  logic [SW-1:0]   step_cnt;
  logic            phase;
  logic [1:0]      rot_idx;
  logic [1:0]      rot_col;
  logic [7:0]      bre_duty;
  logic            dir_up;
  logic [NUM_LANES-1:0][7:0] duty_r, duty_g, duty_b;

  // Lowest newly-pressed button wins.
  always_comb begin
    edge_v  = btn & ~btn_q;
    btn_hit = |edge_v;
    sel_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (edge_v[i]) sel_idx = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= M_OFF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (btn_hit) begin
      case (sel_idx)
        3'd0:    state_d = M_STATIC;
        3'd1:    state_d = M_BLINK;
        3'd2:    state_d = M_ROTATE;
        3'd3:    state_d = M_BREATHE;
        default: state_d = M_OFF;
      endcase
    end
  end

  // btn_q follows btn even in reset, so a button held through reset is not a new press.
  always_ff @(posedge clk) btn_q <= btn;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)                pwm_cnt <= 8'd0;
    else                    pwm_cnt <= pwm_cnt + 8'd1;
    if (rst || btn_hit)     tick_cnt <= '0;
    else if (tick)          tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + TW'(1);
  end

  // Pattern state; an accepted press clears it and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst || btn_hit) begin
      step_cnt <= '0;
      phase    <= 1'b0;
      rot_idx  <= 2'd0;
      rot_col  <= 2'd0;
      bre_duty <= 8'd0;
      dir_up   <= 1'b1;
    end else if (tick) begin
      case (state_q)
        M_BLINK: begin
          if (step_cnt == BLINK_LAST) begin
            step_cnt <= '0;
            phase    <= ~phase;
          end else step_cnt <= step_cnt + SW'(1);
        end
        M_ROTATE: begin
          if (step_cnt == ROT_LAST) begin
            step_cnt <= '0;
            rot_idx  <= rot_idx + 2'd1;
            if (rot_idx == 2'd3) rot_col <= (rot_col == 2'd2) ? 2'd0 : rot_col + 2'd1;
          end else step_cnt <= step_cnt + SW'(1);
        end
        M_BREATHE: begin
          if (dir_up) begin
            if (bre_duty == 8'd255) begin
              dir_up   <= 1'b0;
              bre_duty <= 8'd254;
            end else bre_duty <= bre_duty + 8'd1;
          end else begin
            if (bre_duty == 8'd0) begin
              dir_up   <= 1'b1;
              bre_duty <= 8'd1;
            end else bre_duty <= bre_duty - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    case (state_q)
      M_STATIC: begin
        duty_r = {NUM_LANES{8'hFF}};
        duty_g = {NUM_LANES{8'hFF}};
        duty_b = {NUM_LANES{8'hFF}};
      end
      M_BLINK:   if (phase) duty_r = {NUM_LANES{8'hFF}};
      M_ROTATE: begin
        case (rot_col)
          2'd0:    duty_r[rot_idx] = 8'hFF;
          2'd1:    duty_g[rot_idx] = 8'hFF;
          default: duty_b[rot_idx] = 8'hFF;
        endcase
      end
      M_BREATHE: duty_b = {NUM_LANES{bre_duty}};
      default: ;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    led3_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt),
      .duty_r  (duty_r[l]),
      .duty_g  (duty_g[l]),
      .duty_b  (duty_b[l]),
      .led_r   (led_signal_R[l]),
      .led_g   (led_signal_G[l]),
      .led_b   (led_signal_B[l])
    );
  end

  assign mode = state_q;
endmodule

// File: tb/tb_led3_pattern_sequencer.sv
// Directed bench for led3_pattern_sequencer: mode-decode table plus
// per-cycle pattern checks against a tick/PWM model.

module tb_led3_pattern_sequencer;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [3:0] r, g, b;
  logic [2:0] mode;

  always #5 clk = ~clk;

  led3_pattern_sequencer #(.TICK_DIV(TD), .BLINK_TICKS(BT), .ROT_TICKS(RT)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .led_signal_R (r),
    .led_signal_G (g),
    .led_signal_B (b),
    .mode         (mode)
  );

  typedef struct {
    logic [7:0] btn;
    logic [2:0] exp_mode;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int pwm_m = 0;
  int pwm_pre = 0;

  // One clock; pwm_pre is the PWM count that fed the outputs now visible.
  task automatic step();
    int pre;
    pre = pwm_m;
    @(posedge clk);
    #1;
    pwm_pre = pre;
    pwm_m   = rst ? 0 : (pwm_m + 1) % 256;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int breathe_d(input int n);
    if (n <= 255)      return n;
    else if (n <= 510) return 510 - n;
    else               return n - 510;
  endfunction

  task automatic enter(input logic [7:0] code);
    btn = 8'h00;
    step();
    btn = code;
    step();
  endtask

  // Check `cycles` clocks following a mode-entry edge.
  task automatic run_check(input int md, input int cycles, input string nm);
    logic [3:0] er, eg, eb;
    int n, s, idx, col;
    bit on;
    for (int m = 1; m <= cycles; m++) begin
      step();
      n  = (m - 1) / TD;
      on = (pwm_pre < 255);
      er = 4'h0; eg = 4'h0; eb = 4'h0;
      case (md)
        1: if (on) begin er = 4'hF; eg = 4'hF; eb = 4'hF; end
        2: if (on && ((n / BT) % 2) == 1) er = 4'hF;
        3: begin
          s   = n / RT;
          idx = s % 4;
          col = (s / 4) % 3;
          if (on) begin
            if (col == 0)      er[idx] = 1'b1;
            else if (col == 1) eg[idx] = 1'b1;
            else               eb[idx] = 1'b1;
          end
        end
        4: if (breathe_d(n) > pwm_pre) eb = 4'hF;
        default: ;
      endcase
      check({nm, "_rgb"}, {r, g, b}, {er, eg, eb});
      check({nm, "_mode"}, mode, md);
    end
  endtask

  initial begin
    vec_t vecs[19];
    int cnt[12];

    vecs = '{
      '{8'h00, 3'd0}, '{8'h01, 3'd1}, '{8'h01, 3'd1}, '{8'h00, 3'd1},
      '{8'h02, 3'd2}, '{8'h06, 3'd3}, '{8'h00, 3'd3}, '{8'h08, 3'd4},
      '{8'h00, 3'd4}, '{8'h0C, 3'd3}, '{8'h80, 3'd0}, '{8'h00, 3'd0},
      '{8'h01, 3'd1}, '{8'h00, 3'd1}, '{8'h10, 3'd0}, '{8'hFF, 3'd1},
      '{8'h00, 3'd1}, '{8'hF0, 3'd0}, '{8'h00, 3'd0}
    };

    rst = 1'b1;
    btn = 8'h01;
    repeat (3) step();
    check("reset_mode", mode, 3'd0);
    check("reset_rgb", {r, g, b}, 12'h000);
    rst = 1'b0;
    step();
    check("release_held_mode", mode, 3'd0);
    check("release_held_rgb", {r, g, b}, 12'h000);

    foreach (vecs[i]) begin
      btn = vecs[i].btn;
      step();
      check($sformatf("decode_%0d", i), mode, vecs[i].exp_mode);
    end

    enter(8'h01);
    run_check(1, 20, "static");
    for (int i = 0; i < 12; i++) cnt[i] = 0;
    repeat (256) begin
      step();
      for (int i = 0; i < 4; i++) begin
        cnt[i]     += int'(r[i]);
        cnt[4 + i] += int'(g[i]);
        cnt[8 + i] += int'(b[i]);
      end
    end
    for (int i = 0; i < 12; i++) check($sformatf("static_hi_count_%0d", i), cnt[i], 255);

    enter(8'h02);
    run_check(2, 40, "blink");
    enter(8'h02);
    run_check(2, 20, "blink_reselect");

    enter(8'h04);
    run_check(3, 100, "rotate");

    // Re-press lands on the same edge as the first tick: tick must be dropped.
    enter(8'h04);
    run_check(3, 2, "rotate_pre");
    enter(8'h04);
    run_check(3, 24, "rotate_tick_edge");

    enter(8'h08);
    run_check(4, 2060, "breathe");

    enter(8'h08);
    run_check(4, 50, "breathe_pre_rst");
    rst = 1'b1;
    step();
    check("mid_rst_mode", mode, 3'd0);
    check("mid_rst_rgb", {r, g, b}, 12'h000);
    rst = 1'b0;
    step();
    check("post_rst_mode", mode, 3'd0);
    step();
    check("post_rst_rgb", {r, g, b}, 12'h000);
    enter(8'h08);
    run_check(4, 20, "breathe_restart");

    enter(8'h80);
    run_check(0, 8, "off");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
